eth_tx_arbiter: RTL and testbench
=================================

Name: eth_tx_arbiter

Overview:
- Shares the single GMII transmit path (ahead of the RGMII TX converter) between two frame sources: ARP reply engine (source 0) and UDP transmit engine (source 1).
- Grants one source at a time and muxes its GMII byte stream onto the shared path.
- Enforces a minimum inter-frame gap and bounded ARP priority so UDP cannot starve.
- Revokes a grant that the granted source never uses.

Parameters:
- IFG_CYCLES, 12, idle cycles forced on the shared path after each frame (8..255).
- MAX_ARP_STREAK, 4, consecutive ARP grants allowed while UDP is pending (1..15).
- START_TIMEOUT, 64, cycles a granted source may take to raise tx_en before the grant is revoked (2..255).

Ports:
- clk  in  1  GMII TX clock (125 MHz).
- rstn  in  1  asynchronous active-low reset.
- arp_req  in  1  ARP source requests the path; level, held until granted.
- arp_gnt  out  1  ARP source owns the path.
- arp_tx_en  in  1  ARP GMII enable.
- arp_txd  in  8  ARP GMII data.
- udp_req  in  1  UDP source requests the path.
- udp_gnt  out  1  UDP source owns the path.
- udp_tx_en  in  1  UDP GMII enable.
- udp_txd  in  8  UDP GMII data.
- gmii_tx_en  out  1  shared path enable, registered.
- gmii_txd  out  8  shared path data, registered.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.
- bus_err  out  1  one-cycle pulse for each cycle a non-granted source drives tx_en=1.
- arp_frames  out  16  completed ARP frames, wraps at 0xFFFF->0.
- udp_frames  out  16  completed UDP frames, wraps at 0xFFFF->0.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; streak=0; all timers 0.
- Outputs are registered. gnt rises 1 cycle after the IDLE cycle in which a request is sampled.
- gmii_tx_en/gmii_txd = the granted source's tx_en/txd delayed by 1 cycle. The output is 0/0x00 whenever no grant is held and in all non-BUSY states, except that the final byte of a frame is still flushed.
- Request inputs are ignored outside IDLE.
- FSM states: IDLE, GRANT, BUSY, GAP.
- IDLE:
  - If arp_req=1 and (udp_req=0 or streak<MAX_ARP_STREAK): select ARP.
  - Else if udp_req=1: select UDP.
  - With a selection: assert that gnt, clear timer, go to GRANT.
- Streak:
  - ARP grant with udp_req=1: streak+1 (saturates at 15).
  - ARP grant with udp_req=0: streak=0.
  - UDP grant: streak=0.
- GRANT:
  - Selected tx_en=1: go to BUSY (that byte is forwarded).
  - Else timer+1. When timer reaches START_TIMEOUT-1: deassert gnt, pulse timeout_err, go to GAP. Frame counters do not increment.
- BUSY: forward the stream. On the first cycle with selected tx_en=0: deassert gnt next edge, increment the source's frame counter, go to GAP.
- GAP: count IFG_CYCLES cycles with gmii_tx_en=0, then go to IDLE. The earliest next gnt comes IFG_CYCLES+1 cycles after the frame end is seen.
- The non-granted source's tx_en/txd never reach the output. bus_err pulses every cycle that source's tx_en=1, in any state, including IDLE with no grant.
- Both requests asserted in IDLE: follow the streak rule. Equal-cycle arrival is not a special case.
- Source drops req while granted: the grant is kept. Timeout handles an absent frame.
- Reset mid-frame: gmii_tx_en goes 0 immediately (async). No counter updates.

Test Plan:
- ARP only: arp_req=1, ARP sends a 64-byte frame 3 cycles after arp_gnt → arp_gnt rises 1 cycle after req. gmii_tx_en is high for exactly 64 cycles, delayed 1 cycle from arp_tx_en. Data is byte-exact. arp_frames=1, and the next grant is no earlier than 13 cycles after frame end.
- Starvation guard: arp_req and udp_req held high, each source sends 60-byte frames on grant, defaults → grant order ARP,ARP,ARP,ARP,UDP,ARP,…; udp_frames=1 after the 5th frame.
- Timeout: udp_req=1, UDP never asserts tx_en → udp_gnt falls after 64 cycles, timeout_err pulses once, udp_frames stays 0, gmii_tx_en stays 0.
- Bus error: ARP granted and sending, udp_tx_en=1 for 5 cycles → 5 bus_err pulses, output stream is unchanged ARP data.
- Reset mid-frame: rstn low during byte 20 of a UDP frame → gmii_tx_en=0 and gnt=0 asynchronously, and the counters are cleared to 0. After release, a fresh udp_req is granted normally.
- Counter wrap: preload via 65535 short 1-byte ARP frames, then one more → arp_frames=0x0000.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: grants the shared GMII TX path to the ARP or UDP source with IFG, ARP streak limit and start timeout
module eth_tx_arbiter #(
    parameter int IFG_CYCLES     = 12,
    parameter int MAX_ARP_STREAK = 4,
    parameter int START_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        arp_req,
    output logic        arp_gnt,
    input  logic        arp_tx_en,
    input  logic [7:0]  arp_txd,
    input  logic        udp_req,
    output logic        udp_gnt,
    input  logic        udp_tx_en,
    input  logic [7:0]  udp_txd,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        timeout_err,
    output logic        bus_err,
    output logic [15:0] arp_frames,
    output logic [15:0] udp_frames
);
    typedef enum logic [1:0] {IDLE, GRANT, BUSY, GAP} state_t;
    localparam logic [7:0] IFG_LAST   = 8'(IFG_CYCLES - 1);
    localparam logic [7:0] TO_LAST    = 8'(START_TIMEOUT - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_ARP_STREAK);
    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic        gnt_q, gnt_d;
    logic [7:0]  timer_q, timer_d;
    logic [3:0]  streak_q, streak_d;
    logic        tx_en_q, tx_en_d;
    logic [7:0]  txd_q, txd_d;
    logic        timeout_q, timeout_d;
    logic        bus_err_q, bus_err_d;
    logic [15:0] arp_cnt_q, arp_cnt_d;
    logic [15:0] udp_cnt_q, udp_cnt_d;
    logic        sel_en;
    logic [7:0]  sel_txd;

    assign arp_gnt     = gnt_q & ~sel_q;
    assign udp_gnt     = gnt_q & sel_q;
    assign gmii_tx_en  = tx_en_q;
    assign gmii_txd    = txd_q;
    assign timeout_err = timeout_q;
    assign bus_err     = bus_err_q;
    assign arp_frames  = arp_cnt_q;
    assign udp_frames  = udp_cnt_q;

    // Arbitration FSM: grant selection, stream forwarding, gap/timeout timing and error detection
    always_comb begin
        sel_en    = sel_q ? udp_tx_en : arp_tx_en;
        sel_txd   = sel_q ? udp_txd : arp_txd;
        state_d   = state_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        timer_d   = timer_q;
        streak_d  = streak_q;
        tx_en_d   = 1'b0;
        txd_d     = 8'h00;
        timeout_d = 1'b0;
        arp_cnt_d = arp_cnt_q;
        udp_cnt_d = udp_cnt_q;
        bus_err_d = (arp_tx_en & ~(gnt_q & ~sel_q)) | (udp_tx_en & ~(gnt_q & sel_q));
        case (state_q)
            IDLE: begin
                if (arp_req && (!udp_req || streak_q < STREAK_MAX)) begin
                    sel_d    = 1'b0;
                    gnt_d    = 1'b1;
                    timer_d  = 8'd0;
                    streak_d = udp_req ? ((streak_q == 4'hF) ? streak_q : streak_q + 4'd1) : 4'd0;
                    state_d  = GRANT;
                end else if (udp_req) begin
                    sel_d    = 1'b1;
                    gnt_d    = 1'b1;
                    timer_d  = 8'd0;
                    streak_d = 4'd0;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (sel_en) begin
                    tx_en_d = 1'b1;
                    txd_d   = sel_txd;
                    state_d = BUSY;
                end else if (timer_q == TO_LAST) begin
                    gnt_d     = 1'b0;
                    timeout_d = 1'b1;
                    timer_d   = 8'd0;
                    state_d   = GAP;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            BUSY: begin
                if (sel_en) begin
                    tx_en_d = 1'b1;
                    txd_d   = sel_txd;
                end else begin
                    gnt_d     = 1'b0;
                    timer_d   = 8'd0;
                    arp_cnt_d = sel_q ? arp_cnt_q : arp_cnt_q + 16'd1;
                    udp_cnt_d = sel_q ? udp_cnt_q + 16'd1 : udp_cnt_q;
                    state_d   = GAP;
                end
            end
            GAP: begin
                state_d = (timer_q == IFG_LAST) ? IDLE : GAP;
                timer_d = (timer_q == IFG_LAST) ? timer_q : timer_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            gnt_q     <= 1'b0;
            timer_q   <= 8'd0;
            streak_q  <= 4'd0;
            tx_en_q   <= 1'b0;
            txd_q     <= 8'h00;
            timeout_q <= 1'b0;
            bus_err_q <= 1'b0;
            arp_cnt_q <= 16'd0;
            udp_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            timer_q   <= timer_d;
            streak_q  <= streak_d;
            tx_en_q   <= tx_en_d;
            txd_q     <= txd_d;
            timeout_q <= timeout_d;
            bus_err_q <= bus_err_d;
            arp_cnt_q <= arp_cnt_d;
            udp_cnt_q <= udp_cnt_d;
        end
    end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: scoreboard bench for the two-source GMII TX arbiter
module tb_eth_tx_arbiter;
    logic        clk, rstn;
    logic        arp_req, arp_gnt, arp_tx_en;
    logic [7:0]  arp_txd;
    logic        udp_req, udp_gnt, udp_tx_en;
    logic [7:0]  udp_txd;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;
    logic        timeout_err, bus_err;
    logic [15:0] arp_frames, udp_frames;

    int          n_checks = 0;
    int          n_errors = 0;
    int          gmii_hi  = 0;
    int          bus_cnt  = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] exp_arp = 16'd0;
    logic [15:0] exp_udp = 16'd0;
    int          exp_order[6] = '{0, 0, 0, 0, 1, 0};

    eth_tx_arbiter dut (
        .clk(clk), .rstn(rstn),
        .arp_req(arp_req), .arp_gnt(arp_gnt), .arp_tx_en(arp_tx_en), .arp_txd(arp_txd),
        .udp_req(udp_req), .udp_gnt(udp_gnt), .udp_tx_en(udp_tx_en), .udp_txd(udp_txd),
        .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd),
        .timeout_err(timeout_err), .bus_err(bus_err),
        .arp_frames(arp_frames), .udp_frames(udp_frames)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output int src, output int cyc);
        cyc = 0;
        while (!arp_gnt && !udp_gnt && cyc < 200) begin
            tick;
            cyc++;
        end
        if (!arp_gnt && !udp_gnt) check("gnt_wait_expired", 32'(arp_gnt | udp_gnt), 32'd1);
        src = udp_gnt ? 1 : 0;
    endtask

    task automatic send(input int src, input int len, input int inj);
        logic [7:0] b;
        logic       other;
        for (int i = 0; i < len; i++) begin
            b     = 8'($urandom);
            other = (i >= 5 && i < 5 + inj);
            if (src == 0) begin
                arp_tx_en = 1'b1; arp_txd = b;
                udp_tx_en = other; udp_txd = other ? 8'hEE : 8'h00;
            end else begin
                udp_tx_en = 1'b1; udp_txd = b;
                arp_tx_en = other; arp_txd = other ? 8'hEE : 8'h00;
            end
            exp_q.push_back(b);
            tick;
        end
        arp_tx_en = 1'b0; arp_txd = 8'h00;
        udp_tx_en = 1'b0; udp_txd = 8'h00;
        tick;
        if (src == 0) exp_arp++;
        else exp_udp++;
    endtask

    // Output monitor: pops the scoreboard on every forwarded byte and counts bus errors
    always @(posedge clk) begin
        #1;
        if (bus_err) bus_cnt++;
        if (gmii_tx_en) begin
            gmii_hi++;
            if (exp_q.size() == 0) check("gmii_extra_byte", 32'(gmii_tx_en), 32'd0);
            else check("gmii_txd", 32'(gmii_txd), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int s, c, g0, b0, fall, to_cnt;
        rstn = 1'b0;
        arp_req = 1'b0; arp_tx_en = 1'b0; arp_txd = 8'h00;
        udp_req = 1'b0; udp_tx_en = 1'b0; udp_txd = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_arp_gnt", 32'(arp_gnt), 32'd0);
        check("rst_udp_gnt", 32'(udp_gnt), 32'd0);
        check("rst_gmii_en", 32'(gmii_tx_en), 32'd0);
        check("rst_gmii_txd", 32'(gmii_txd), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_arp_frames", 32'(arp_frames), 32'd0);
        check("rst_udp_frames", 32'(udp_frames), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick;

        arp_req = 1'b1;
        tick;
        check("arp_gnt_latency", 32'(arp_gnt), 32'd1);
        arp_req = 1'b0;
        repeat (3) tick;
        check("pre_frame_idle_out", 32'(gmii_tx_en), 32'd0);
        g0 = gmii_hi;
        send(0, 64, 0);
        check("arp64_len", 32'(gmii_hi - g0), 32'd64);
        check("arp64_flushed", 32'(gmii_tx_en), 32'd0);
        check("arp64_gnt_drop", 32'(arp_gnt), 32'd0);
        check("arp64_frames", 32'(arp_frames), 32'(exp_arp));
        arp_req = 1'b1;
        wait_gnt(s, c);
        check("ifg_regrant_cycles", 32'(c), 32'd13);
        arp_req = 1'b0;
        send(0, 1, 0);

        arp_req = 1'b1;
        udp_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_gnt(s, c);
            check($sformatf("order_%0d", k), 32'(s), 32'(exp_order[k]));
            check($sformatf("gap_%0d", k), 32'(c), 32'd13);
            if (k == 5) begin
                arp_req = 1'b0;
                udp_req = 1'b0;
            end
            send(s, 60, 0);
            if (k == 4) check("udp_frames_5th", 32'(udp_frames), 32'(exp_udp));
        end
        check("starve_arp_frames", 32'(arp_frames), 32'(exp_arp));

        udp_req = 1'b1;
        wait_gnt(s, c);
        check("timeout_src", 32'(s), 32'd1);
        udp_req = 1'b0;
        g0 = gmii_hi;
        fall = 0;
        to_cnt = 0;
        for (int i = 1; i <= 80; i++) begin
            tick;
            if (timeout_err) to_cnt++;
            if (!udp_gnt && fall == 0) fall = i;
        end
        check("timeout_gnt_fall", 32'(fall), 32'd64);
        check("timeout_pulses", 32'(to_cnt), 32'd1);
        check("timeout_no_output", 32'(gmii_hi - g0), 32'd0);
        check("timeout_udp_frames", 32'(udp_frames), 32'(exp_udp));

        b0 = bus_cnt;
        arp_tx_en = 1'b1;
        arp_txd = 8'h55;
        repeat (2) tick;
        arp_tx_en = 1'b0;
        arp_txd = 8'h00;
        repeat (2) tick;
        check("idle_bus_err", 32'(bus_cnt - b0), 32'd2);

        arp_req = 1'b1;
        wait_gnt(s, c);
        check("arp_gnt_latency2", 32'(c), 32'd1);
        arp_req = 1'b0;
        b0 = bus_cnt;
        send(0, 20, 5);
        tick;
        check("busy_bus_err", 32'(bus_cnt - b0), 32'd5);
        check("bus_err_arp_frames", 32'(arp_frames), 32'(exp_arp));

        udp_req = 1'b1;
        wait_gnt(s, c);
        check("rst_test_src", 32'(s), 32'd1);
        udp_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            udp_tx_en = 1'b1;
            udp_txd = 8'($urandom);
            exp_q.push_back(udp_txd);
            tick;
        end
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_gmii_en", 32'(gmii_tx_en), 32'd0);
        check("midrst_udp_gnt", 32'(udp_gnt), 32'd0);
        check("midrst_arp_frames", 32'(arp_frames), 32'd0);
        check("midrst_udp_frames", 32'(udp_frames), 32'd0);
        check("midrst_queue", 32'(exp_q.size()), 32'd0);
        udp_tx_en = 1'b0;
        udp_txd = 8'h00;
        exp_arp = 16'd0;
        exp_udp = 16'd0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        tick;
        udp_req = 1'b1;
        tick;
        check("post_rst_udp_gnt", 32'(udp_gnt), 32'd1);
        udp_req = 1'b0;
        send(1, 10, 0);
        check("post_rst_udp_frames", 32'(udp_frames), 32'(exp_udp));

        repeat (14) tick;
        force dut.arp_cnt_q = 16'hFFFE;
        repeat (2) tick;
        release dut.arp_cnt_q;
        exp_arp = 16'hFFFE;
        for (int k = 0; k < 2; k++) begin
            arp_req = 1'b1;
            wait_gnt(s, c);
            arp_req = 1'b0;
            send(0, 1, 0);
            check($sformatf("wrap_arp_frames_%0d", k), 32'(arp_frames), 32'(exp_arp));
        end

        repeat (2) tick;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
